// File: rtl/matrix_transpose_stream.sv
// Streaming NUM_MG x NUM_PE transpose: rows in, columns (or rows) out, ping-pong banked.
// Optional MT_STREAM_LAST_EN adds out_last marking the final beat of each matrix.

module matrix_transpose_stream_lane #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  transpose,
   input  logic                  val,
   input  logic [DATA_WIDTH-1:0] col_elem,
   input  logic [DATA_WIDTH-1:0] row_elem,
   output logic [DATA_WIDTH-1:0] elem
);
   assign elem = !val ? '0 : (transpose ? col_elem : row_elem);
endmodule

module matrix_transpose_stream #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_MG     = 8,
   parameter int NUM_PE     = NUM_MG
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ctrl,
   input  logic                         in_val,
   output logic                         in_rdy,
   input  logic [NUM_PE*DATA_WIDTH-1:0] in_row,
   output logic                         out_val,
   input  logic                         out_rdy,
`ifdef MT_STREAM_LAST_EN
   output logic                         out_last,
`endif
   output logic [NUM_MG*DATA_WIDTH-1:0] out_vec
);
   localparam int CW = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_MG - 1);

   if (NUM_PE != NUM_MG) begin : g_bad_param
      $error("matrix_transpose_stream: NUM_PE must equal NUM_MG");
   end

   logic [DATA_WIDTH-1:0] mem [2][NUM_MG][NUM_PE];
   logic          wr_bank, rd_bank;
   logic [CW-1:0] wr_cnt, rd_cnt;
   logic [1:0]    full, mode;
   logic          in_fire, out_fire;

   assign in_rdy   = !full[wr_bank];
   assign out_val  = full[rd_bank];
   assign in_fire  = in_val & in_rdy;
   assign out_fire = out_val & out_rdy;

`ifdef MT_STREAM_LAST_EN
   assign out_last = out_val & (rd_cnt == LAST);
`endif

   // full[wr_bank] and full[rd_bank] can never be updated together on the same
   // bank: a write needs the bank empty and a read needs it full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         full    <= '0;
         mode    <= '0;
      end else begin
         if (in_fire) begin
            if (wr_cnt == '0) mode[wr_bank] <= ctrl;
            if (wr_cnt == LAST) begin
               wr_cnt        <= '0;
               wr_bank       <= ~wr_bank;
               full[wr_bank] <= 1'b1;
            end else begin
               wr_cnt <= wr_cnt + CW'(1);
            end
         end
         if (out_fire) begin
            if (rd_cnt == LAST) begin
               rd_cnt        <= '0;
               rd_bank       <= ~rd_bank;
               full[rd_bank] <= 1'b0;
            end else begin
               rd_cnt <= rd_cnt + CW'(1);
            end
         end
      end
   end

   // Bank storage carries no reset; stale contents are never visible since full is cleared.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         for (int j = 0; j < NUM_PE; j++)
            mem[wr_bank][wr_cnt][j] <= in_row[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   for (genvar k = 0; k < NUM_MG; k++) begin : g_lane
      matrix_transpose_stream_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .transpose (mode[rd_bank]),
         .val       (out_val),
         .col_elem  (mem[rd_bank][k][rd_cnt]),
         .row_elem  (mem[rd_bank][rd_cnt][k]),
         .elem      (out_vec[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Randomized bench for matrix_transpose_stream; a matrix-level scoreboard predicts every output beat.
module tb_matrix_transpose_stream;
   localparam int DW = 16;
   localparam int MG = 4;
   localparam int W  = DW * MG;

   logic         clk = 1'b0;
   logic         rst_n, ctrl, in_val, out_rdy;
   logic         in_rdy, out_val;
   logic [W-1:0] in_row, out_vec;
`ifdef MT_STREAM_LAST_EN
   logic         out_last;
`endif

   int n_cmp = 0;
   int n_err = 0;

   matrix_transpose_stream #(.DATA_WIDTH(DW), .NUM_MG(MG), .NUM_PE(MG)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl    (ctrl),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_row  (in_row),
      .out_val (out_val),
      .out_rdy (out_rdy),
`ifdef MT_STREAM_LAST_EN
      .out_last(out_last),
`endif
      .out_vec (out_vec)
   );

   always #5 clk = ~clk;

   // Reference model: collect whole matrices, then queue the vectors they should produce.
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] pm [MG][MG];
   int            prow = 0;
   int            beat = 0;
   logic          pmode = 1'b0;
   logic          stall = 1'b0;
   logic [W-1:0]  held = '0;
   logic [W-1:0]  vec, e;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prow  = 0;
         beat  = 0;
         stall = 1'b0;
      end else begin
         if (stall) begin
            n_cmp++;
            if (out_val !== 1'b1 || out_vec !== held) begin
               n_err++;
               $display("FAIL stall_hold: val=%0b vec=%h required val=1 vec=%h", out_val, out_vec, held);
            end
         end
`ifdef MT_STREAM_LAST_EN
         n_cmp++;
         if (out_last !== (out_val && beat == MG-1)) begin
            n_err++;
            $display("FAIL out_last: got %0b required %0b", out_last, out_val && beat == MG-1);
         end
`endif
         if (out_val) begin
            if (out_rdy) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_beat: vec=%h required no output", out_vec);
               end else begin
                  e = exp_q.pop_front();
                  if (out_vec !== e) begin
                     n_err++;
                     $display("FAIL out_vec: got %h required %h", out_vec, e);
                  end
               end
               beat = (beat + 1) % MG;
            end
         end else begin
            n_cmp++;
            if (out_vec !== '0) begin
               n_err++;
               $display("FAIL idle_zero: got %h required 0", out_vec);
            end
         end
         stall = out_val && !out_rdy;
         held  = out_vec;
         if (in_val && in_rdy) begin
            if (prow == 0) pmode = ctrl;
            for (int c = 0; c < MG; c++) pm[prow][c] = in_row[c*DW +: DW];
            if (prow == MG-1) begin
               for (int v = 0; v < MG; v++) begin
                  for (int k = 0; k < MG; k++)
                     vec[k*DW +: DW] = pmode ? pm[k][v] : pm[v][k];
                  exp_q.push_back(vec);
               end
               prow = 0;
            end else begin
               prow++;
            end
         end
      end
   end

   function automatic logic [W-1:0] rnd_row();
      logic [W-1:0] r;
      for (int c = 0; c < MG; c++) r[c*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   task automatic send_row(input logic [W-1:0] row, input logic c, output int waits);
      logic acc;
      in_row = row;
      ctrl   = c;
      in_val = 1'b1;
      waits  = 0;
      do begin
         @(negedge clk);
         acc = in_rdy;
         @(posedge clk);
         #1;
         waits++;
      end while (!acc && waits < 200);
      n_cmp++;
      if (!acc) begin
         n_err++;
         $display("FAIL send_timeout: in_rdy=%0b required 1 within 200 cycles", acc);
      end
   endtask

   task automatic drain(input logic rand_rdy);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      out_rdy = 1'b1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d beats left required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp += 3;
      if (out_val !== 1'b0) begin n_err++; $display("FAIL reset_out_val: got %0b required 0", out_val); end
      if (out_vec !== '0)   begin n_err++; $display("FAIL reset_out_vec: got %h required 0", out_vec); end
      if (in_rdy !== 1'b1)  begin n_err++; $display("FAIL reset_in_rdy: got %0b required 1", in_rdy); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single_transpose();
      int w;
      logic [W-1:0] r;
      out_rdy = 1'b1;
      for (int row = 0; row < MG; row++) begin
         for (int c = 0; c < MG; c++) r[c*DW +: DW] = DW'(16*row + c);
         if (row < MG-1) begin
            send_row(r, 1'b1, w);
         end else begin
            in_row = r;
            ctrl   = 1'b1;
            in_val = 1'b1;
            @(negedge clk);
            n_cmp += 2;
            if (out_val !== 1'b0) begin n_err++; $display("FAIL early_out_val: got %0b required 0", out_val); end
            if (in_rdy !== 1'b1)  begin n_err++; $display("FAIL single_in_rdy: got %0b required 1", in_rdy); end
            @(posedge clk);
            #1;
            in_val = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_val !== 1'b1) begin n_err++; $display("FAIL first_out_latency: got %0b required 1", out_val); end
         end
      end
      drain(1'b0);
   endtask

   task automatic test_passthrough();
      int w;
      for (int row = 0; row < MG; row++) send_row(rnd_row(), row != 0, w);
      in_val = 1'b0;
      drain(1'b0);
   endtask

   task automatic test_back_to_back();
      out_rdy = 1'b1;
      fork
         begin
            int w;
            for (int i = 0; i < 3*MG; i++) begin
               send_row(rnd_row(), 1'b1, w);
               n_cmp++;
               if (w != 1) begin n_err++; $display("FAIL b2b_in_rdy: waits %0d required 1", w); end
            end
            in_val = 1'b0;
         end
         begin
            int t = 0;
            do begin @(negedge clk); t++; end while (!out_val && t < 20);
            n_cmp++;
            if (out_val !== 1'b1) begin n_err++; $display("FAIL b2b_start: out_val %0b required 1", out_val); end
            for (int i = 1; i < 3*MG; i++) begin
               @(negedge clk);
               n_cmp++;
               if (out_val !== 1'b1) begin n_err++; $display("FAIL b2b_gap: beat %0d out_val %0b required 1", i, out_val); end
            end
         end
      join
      drain(1'b0);
   endtask

   task automatic test_backpressure();
      int w;
      out_rdy = 1'b0;
      for (int i = 0; i < 2*MG; i++) send_row(rnd_row(), 1'($urandom_range(0, 1)), w);
      in_row = rnd_row();
      ctrl   = 1'($urandom_range(0, 1));
      in_val = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (in_rdy !== 1'b0) begin n_err++; $display("FAIL full_held_off: in_rdy %0b required 0", in_rdy); end
         @(posedge clk);
         #1;
      end
      out_rdy = 1'b1;
      for (int i = 0; i <= MG; i++) begin
         @(negedge clk);
         n_cmp++;
         if (in_rdy !== (i == MG)) begin
            n_err++;
            $display("FAIL in_rdy_release: cycle %0d in_rdy %0b required %0b", i, in_rdy, i == MG);
         end
         @(posedge clk);
         #1;
      end
      for (int i = 1; i < MG; i++) send_row(rnd_row(), 1'($urandom_range(0, 1)), w);
      in_val = 1'b0;
      drain(1'b1);
   endtask

   task automatic test_reset_mid();
      int w;
      out_rdy = 1'b0;
      for (int i = 0; i < MG; i++) send_row(rnd_row(), 1'b1, w);
      out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      out_rdy = 1'b0;
      for (int i = 0; i < 2; i++) send_row(rnd_row(), 1'b1, w);
      in_val = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      out_rdy = 1'b1;
      @(negedge clk);
      n_cmp += 3;
      if (out_val !== 1'b0) begin n_err++; $display("FAIL midrst_out_val: got %0b required 0", out_val); end
      if (out_vec !== '0)   begin n_err++; $display("FAIL midrst_out_vec: got %h required 0", out_vec); end
      if (in_rdy !== 1'b1)  begin n_err++; $display("FAIL midrst_in_rdy: got %0b required 1", in_rdy); end
      @(posedge clk);
      #1;
      for (int i = 0; i < MG; i++) send_row(rnd_row(), 1'($urandom_range(0, 1)), w);
      in_val = 1'b0;
      drain(1'b1);
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (out_val !== 1'b0) begin n_err++; $display("FAIL stale_beat: out_val %0b required 0", out_val); end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      ctrl    = 1'b0;
      in_val  = 1'b0;
      out_rdy = 1'b0;
      in_row  = '0;
      test_reset();
      test_single_transpose();
      test_passthrough();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/matrix_transpose_stream.md
Name: matrix_transpose_stream

Overview:
Streaming counterpart of the single-cycle parallel transpose. Accepts a square NUM_MG x NUM_PE matrix one row per beat over a valid/ready interface, and emits it one column per beat, or one row per beat in pass-through mode. Ping-pong double buffering sustains one beat per cycle in steady state. It sits between memory-group row streams and the PE array, where a full parallel matrix bus is not available.

Parameters:
DATA_WIDTH, 64, bit width of one matrix element
NUM_MG, 8, matrix rows (memory groups)
NUM_PE, NUM_MG, matrix columns (PEs); must equal NUM_MG, elaboration error otherwise

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ctrl  in  1  1 = transpose, 0 = pass-through; sampled on first row beat of each matrix
in_val  in  1  input row valid
in_rdy  out  1  input row ready
in_row  in  DATA_WIDTH x NUM_PE  input row; element j = column j
out_val  out  1  output vector valid
out_rdy  in  1  downstream ready
out_vec  out  DATA_WIDTH x NUM_MG  output vector; element k

Behaviour:
- Storage: two banks B0 and B1, each NUM_MG x NUM_PE x DATA_WIDTH, plus per-bank full flag and mode bit.
- Write side: wr_bank pointer and wr_cnt (0..NUM_MG-1). Input handshake = in_val & in_rdy. On a handshake, in_row is written to row wr_cnt of wr_bank.
  - If wr_cnt==0, ctrl is latched into that bank's mode bit. ctrl is ignored on all other beats.
  - On the beat where wr_cnt==NUM_MG-1: the bank's full flag is set, wr_cnt wraps to 0, and wr_bank toggles.
- in_rdy = !full[wr_bank]. It is combinational from registers only, with no dependence on in_val.
- Read side: rd_bank pointer and rd_cnt (0..NUM_PE-1).
  - out_val = full[rd_bank].
  - Transpose mode: out_vec[k] = bank[k][rd_cnt], i.e. column rd_cnt.
  - Pass-through mode: out_vec[k] = bank[rd_cnt][k], i.e. row rd_cnt.
  - out_vec is driven all-zero whenever out_val==0.
- Output handshake = out_val & out_rdy: rd_cnt increments. On the beat where rd_cnt==NUM_PE-1, full[rd_bank] clears, rd_cnt wraps to 0, and rd_bank toggles.
- Latency: out_val rises the cycle after the last row handshake of a matrix. Empty-to-first-output latency = NUM_MG beats + 1 cycle.
- Throughput: with out_rdy held high, one row in and one vector out per cycle, with no bubbles across matrix boundaries.
- Simultaneous events:
  - A write into one bank and a read from the other bank in the same cycle are independent.
  - If the last read of a bank and the first write into that same bank fall in the same cycle, the write is not accepted: in_rdy was low that cycle. No read/write hazard is possible.
- Full condition: both banks full -> in_rdy=0. Input is held off until the first column drain of rd_bank completes; in_rdy rises the cycle after that final read beat.
- Empty condition: both banks not full -> out_val=0, out_vec=0.
- Backpressure: out_vec and out_val are stable while out_val & !out_rdy.
- Reset (rst_n==0 at a clock edge), including mid-matrix:
  - wr_cnt, rd_cnt, wr_bank, rd_bank, full flags and mode bits all go to 0.
  - Outputs are then out_val=0, out_vec=0, in_rdy=1.
  - Partially written or partially drained matrices are discarded. Bank contents are not cleared.

Optional Feature:
MT_STREAM_LAST_EN:
- Defined: adds output port out_last (1 bit). out_last = out_val & (rd_cnt==NUM_PE-1), and is 0 in reset.
- Not defined: the out_last port does not exist; all other behaviour is identical.

Test Plan:
1. Single transpose: NUM_MG=4, DATA_WIDTH=16, rst_n low 2 cycles, out_rdy=1, ctrl=1. Stream rows where element (r,c)=16*r+c. -> out_val first high the cycle after row 3 is accepted; out_vec over 4 beats = {0,16,32,48}, {1,17,33,49}, {2,18,34,50}, {3,19,35,51}; out_last (if enabled) only on the 4th beat.
2. Pass-through and mode latching: ctrl=0 on beat 0, then ctrl=1 on beats 1-3. -> output rows are identical to input rows, in order (mode latched from beat 0).
3. Back-to-back: 3 matrices, in_val and out_rdy held 1. -> in_rdy never drops; 12 consecutive output beats with no gap; each matrix transposed correctly.
4. Backpressure and full: out_rdy=0 while streaming 2 matrices. -> in_rdy drops after the 8th row; a 9th row held on in_val is not accepted. Then raise out_rdy: in_rdy rises the cycle after the 4th output beat; the 9th row becomes the first row of matrix 3; out_vec is held stable during stalls.
5. Reset mid-operation: assert rst_n=0 after 2 rows of matrix 0 and with matrix -1 half-drained. -> next cycle out_val=0, out_vec=0, in_rdy=1; a fresh matrix then transposes correctly with no stale beats emitted.
